// File: rtl/wb_pkg.sv
// Shared Wishbone bundle widths and owner encoding.
// Interconnect blocks import this package so their port widths stay consistent.
package wb_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = WB_DW / 8;

    // One-hot bus owner as seen on owner_o, {m1, m0}
    typedef enum logic [1:0] {
        OWNER_NONE = 2'b00,
        OWNER_M0   = 2'b01,
        OWNER_M1   = 2'b10
    } owner_t;

endpackage : wb_pkg

// File: rtl/wb_arbiter_2m.sv
// Two-master to one-slave pipelined Wishbone B4 arbiter. Ownership is held for a whole
// cyc cycle; an outstanding-request counter throttles strobes and routes responses.
//
// Handshake: a request transfers on a cycle where stb is high and stall is low, and each
// transferred request is answered by exactly one ack or err. The arbiter raises stall to
// the owner while the outstanding window is full, and always to the non-owner.
module wb_arbiter_2m
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH      = WB_AW,
    parameter int DATA_WIDTH      = WB_DW,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ROUND_ROBIN     = 1
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,

    input  logic                      m0_wb_cyc_i,
    input  logic                      m0_wb_stb_i,
    input  logic                      m0_wb_we_i,
    input  logic [ADDR_WIDTH-1:0]     m0_wb_adr_i,
    input  logic [DATA_WIDTH-1:0]     m0_wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0]   m0_wb_sel_i,
    output logic                      m0_wb_stall_o,
    output logic                      m0_wb_ack_o,
    output logic                      m0_wb_err_o,
    output logic [DATA_WIDTH-1:0]     m0_wb_dat_o,

    input  logic                      m1_wb_cyc_i,
    input  logic                      m1_wb_stb_i,
    input  logic                      m1_wb_we_i,
    input  logic [ADDR_WIDTH-1:0]     m1_wb_adr_i,
    input  logic [DATA_WIDTH-1:0]     m1_wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0]   m1_wb_sel_i,
    output logic                      m1_wb_stall_o,
    output logic                      m1_wb_ack_o,
    output logic                      m1_wb_err_o,
    output logic [DATA_WIDTH-1:0]     m1_wb_dat_o,

    output logic                      s_wb_cyc_o,
    output logic                      s_wb_stb_o,
    output logic                      s_wb_we_o,
    output logic [ADDR_WIDTH-1:0]     s_wb_adr_o,
    output logic [DATA_WIDTH-1:0]     s_wb_dat_o,
    output logic [DATA_WIDTH/8-1:0]   s_wb_sel_o,
    input  logic                      s_wb_stall_i,
    input  logic                      s_wb_ack_i,
    input  logic                      s_wb_err_i,
    input  logic [DATA_WIDTH-1:0]     s_wb_dat_i,

    output logic [1:0]                owner_o
);

    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rr_last_q, rr_last_d;   // 1: m1 was granted last

    logic                  own0, own1, own_any;
    logic                  own_cyc, own_stb, own_we;
    logic [ADDR_WIDTH-1:0] own_adr;
    logic [DATA_WIDTH-1:0] own_dat;
    logic [SEL_W-1:0]      own_sel;
    logic                  cnt_full, cnt_nz;
    logic                  resp_ok, own_stall;
    logic                  inc, dec;
    logic                  grant_m1;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            count_q   <= '0;
            rr_last_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rr_last_q <= rr_last_d;
        end
    end

    // Owner request mux and slave-side forwarding
    always_comb begin
        own0    = (state_q == OWN0);
        own1    = (state_q == OWN1);
        own_any = own0 | own1;

        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        if (own0) begin
            own_cyc = m0_wb_cyc_i;
            own_stb = m0_wb_stb_i;
            own_we  = m0_wb_we_i;
            own_adr = m0_wb_adr_i;
            own_dat = m0_wb_dat_i;
            own_sel = m0_wb_sel_i;
        end else if (own1) begin
            own_cyc = m1_wb_cyc_i;
            own_stb = m1_wb_stb_i;
            own_we  = m1_wb_we_i;
            own_adr = m1_wb_adr_i;
            own_dat = m1_wb_dat_i;
            own_sel = m1_wb_sel_i;
        end

        cnt_full  = (count_q == CNT_MAX);
        cnt_nz    = (count_q != '0);
        own_stall = s_wb_stall_i | cnt_full;

        // Dropping cyc aborts the cycle immediately, so cyc/stb follow the owner's cyc
        s_wb_cyc_o = own_cyc;
        s_wb_stb_o = own_cyc & own_stb & ~cnt_full;
        s_wb_we_o  = own_we;
        s_wb_adr_o = own_adr;
        s_wb_dat_o = own_dat;
        s_wb_sel_o = own_sel;

        // Responses with nothing outstanding are spurious and swallowed
        resp_ok = own_cyc & cnt_nz;
    end

    // Per-master response and stall routing
    always_comb begin
        m0_wb_stall_o = own0 ? own_stall : 1'b1;
        m0_wb_ack_o   = own0 & resp_ok & s_wb_ack_i;
        m0_wb_err_o   = own0 & resp_ok & s_wb_err_i;
        m0_wb_dat_o   = (own0 & resp_ok) ? s_wb_dat_i : '0;

        m1_wb_stall_o = own1 ? own_stall : 1'b1;
        m1_wb_ack_o   = own1 & resp_ok & s_wb_ack_i;
        m1_wb_err_o   = own1 & resp_ok & s_wb_err_i;
        m1_wb_dat_o   = (own1 & resp_ok) ? s_wb_dat_i : '0;

        owner_o = {own1, own0};
    end

    // Next-state, grant and outstanding counter
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rr_last_d = rr_last_q;
        grant_m1  = 1'b0;
        inc       = s_wb_stb_o & ~s_wb_stall_i;
        dec       = (s_wb_ack_i | s_wb_err_i) & cnt_nz;

        case (state_q)
            IDLE: begin
                count_d = '0;
                if (m0_wb_cyc_i && m1_wb_cyc_i) begin
                    grant_m1 = (ROUND_ROBIN != 0) ? ~rr_last_q : 1'b1;
                end else begin
                    grant_m1 = m1_wb_cyc_i;
                end
                if (m0_wb_cyc_i || m1_wb_cyc_i) begin
                    state_d   = grant_m1 ? OWN1 : OWN0;
                    rr_last_d = grant_m1;
                end
            end
            OWN0, OWN1: begin
                if (!own_cyc) begin
                    // Outstanding responses are abandoned on release
                    state_d = IDLE;
                    count_d = '0;
                end else if (inc && !dec) begin
                    count_d = count_q + CNT_ONE;
                end else if (dec && !inc) begin
                    count_d = count_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase

        if (!own_any && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

endmodule : wb_arbiter_2m
